// File: rtl/sat_arb4.sv
// Four-requester round-robin scheduler feeding one signed-to-unsigned saturation
// stage, with a registered output, sticky per-channel clip flags and a clip counter.
module sat_arb4 #(
  parameter int isz = 17,
  parameter int osz = 12,
  parameter int cw  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_valid,
  input  logic [4*isz-1:0]   in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [osz-1:0]     out_data,
  output logic [1:0]         out_ch,
  output logic               out_sat,
  output logic [3:0]         sat_flags,
  input  logic               sat_clr,
  output logic [cw-1:0]      sat_cnt
);

  logic                  out_valid_q, out_valid_d;
  logic [osz-1:0]        out_data_q, out_data_d;
  logic [1:0]            out_ch_q, out_ch_d;
  logic                  out_sat_q, out_sat_d;
  logic [3:0]            sat_flags_q, sat_flags_d;
  logic [cw-1:0]         sat_cnt_q, sat_cnt_d;
  logic [1:0]            ptr_q, ptr_d;

  logic                  load_ok;
  logic [3:0]            grant;
  logic                  gnt_any;
  logic [1:0]            gnt_idx;
  logic [1:0]            cand;
  logic signed [isz-1:0] sample;
  logic [osz-1:0]        sat_val;
  logic                  is_sat;

  // Rotating search starting at ptr; reset and backpressure suppress any grant.
  always_comb begin
    load_ok = ~out_valid_q | out_ready;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = 0; j < 4; j++) begin
      cand = ptr_q + 2'(j);
      if (!gnt_any && load_ok && !reset && in_valid[cand]) begin
        gnt_any     = 1'b1;
        gnt_idx     = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    sample  = in_data[gnt_idx*isz +: isz];
    sat_val = sample[osz-1:0];
    is_sat  = 1'b0;
    if (sample[isz-1]) begin
      sat_val = '0;
      is_sat  = 1'b1;
    end else if (|sample[isz-2:osz]) begin
      sat_val = '1;
      is_sat  = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_sat_d   = out_sat_q;
    ptr_d       = ptr_q;
    sat_flags_d = sat_clr ? 4'b0000 : sat_flags_q;
    sat_cnt_d   = sat_clr ? '0 : sat_cnt_q;
    if (gnt_any) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_val;
      out_ch_d    = gnt_idx;
      out_sat_d   = is_sat;
      ptr_d       = gnt_idx + 2'd1;
      // A clip event in the same cycle as a clear survives the clear.
      if (is_sat) begin
        sat_flags_d = (sat_clr ? 4'b0000 : sat_flags_q) | grant;
        if (sat_clr)
          sat_cnt_d = cw'(1);
        else if (!(&sat_cnt_q))
          sat_cnt_d = sat_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_flags_q <= '0;
      sat_cnt_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_sat_q   <= out_sat_d;
      sat_flags_q <= sat_flags_d;
      sat_cnt_q   <= sat_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = grant;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_sat   = out_sat_q;
  assign sat_flags = sat_flags_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sat_arb4.sv
// Randomised and directed bench for sat_arb4, checked every cycle against a
// behavioural model of the round-robin/saturation rules (counter width 4).
module tb_sat_arb4;

  localparam int ISZ = 17;
  localparam int OSZ = 12;
  localparam int CW  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         in_valid;
  logic [4*ISZ-1:0]   in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [OSZ-1:0]     out_data;
  logic [1:0]         out_ch;
  logic               out_sat;
  logic [3:0]         sat_flags;
  logic               sat_clr;
  logic [CW-1:0]      sat_cnt;

  int vectors = 0;
  int miscompares = 0;

  sat_arb4 #(.isz(ISZ), .osz(OSZ), .cw(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
    .sat_flags(sat_flags), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*ISZ-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] t [4];
    logic [4*ISZ-1:0] r;
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*ISZ +: ISZ] = t[i][ISZ-1:0];
    return r;
  endfunction

  logic [3:0] last_ready;

  // One clock cycle with the given inputs; in_ready is captured mid-cycle.
  task automatic applyStimulus(input logic [3:0] v, input logic [4*ISZ-1:0] d,
                               input logic ordy, input logic clr, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    sat_clr   = clr;
    reset     = rst;
    #1;
    last_ready = in_ready;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  bit  live = 0;
  int  m_valid, m_data, m_ch, m_sat, m_flags, m_cnt, m_ptr;
  int  gk, s, idx;
  logic signed [ISZ-1:0] raw;
  logic [3:0] exp_ready;

  always @(negedge clk) begin
    gk = -1;
    if (live && !reset && (m_valid == 0 || out_ready)) begin
      for (int j = 0; j < 4; j++) begin
        idx = (m_ptr + j) % 4;
        if (gk < 0 && in_valid[idx]) gk = idx;
      end
    end
    exp_ready = (gk >= 0) ? (4'b0001 << gk) : 4'b0000;
    if (live) begin
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("out_valid", 32'(out_valid), m_valid);
      checkOutput("out_data", 32'(out_data), m_data);
      checkOutput("out_ch", 32'(out_ch), m_ch);
      checkOutput("out_sat", 32'(out_sat), m_sat);
      checkOutput("sat_flags", 32'(sat_flags), m_flags);
      checkOutput("sat_cnt", 32'(sat_cnt), m_cnt);
    end
    if (reset) begin
      live = 1;
      m_valid = 0; m_data = 0; m_ch = 0; m_sat = 0;
      m_flags = 0; m_cnt = 0; m_ptr = 0;
    end else if (live) begin
      if (sat_clr) begin
        m_flags = 0;
        m_cnt = 0;
      end
      if (gk >= 0) begin
        raw = in_data[gk*ISZ +: ISZ];
        s = int'(raw);
        m_valid = 1;
        m_ch = gk;
        m_ptr = (gk + 1) % 4;
        if (s < 0) begin
          m_data = 0; m_sat = 1;
        end else if (s >= (1 << OSZ)) begin
          m_data = (1 << OSZ) - 1; m_sat = 1;
        end else begin
          m_data = s; m_sat = 0;
        end
        if (m_sat == 1) begin
          m_flags = m_flags | (1 << gk);
          if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  function automatic int randSample();
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 4095));
      1: return int'($urandom_range(4090, 4100));
      2: return -int'($urandom_range(0, 3));
      3: return -65536;
      default: return int'($urandom);
    endcase
  endfunction

  bit got3;

  initial begin
    in_valid = '0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0; reset = 1'b1;
    last_ready = '0;
    @(posedge clk); #1;
    applyStimulus(4'b0000, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_sat_cnt", 32'(sat_cnt), 0);
    checkOutput("reset_sat_flags", 32'(sat_flags), 0);

    // Round robin over four busy channels
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, pack4(100, 200, 300, 400), 1'b1, 1'b0, 1'b0);
    checkOutput("rr_out_ch", 32'(out_ch), 3);
    checkOutput("rr_out_data", 32'(out_data), 400);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, pack4(100, 200, 300, 400), 1'b1, 1'b0, 1'b0);

    // Saturation boundaries on channel 2
    applyStimulus(4'b0100, pack4(0, 0, -1, 0), 1'b1, 1'b0, 1'b0);
    checkOutput("bnd_m1_data", 32'(out_data), 0);
    checkOutput("bnd_m1_sat", 32'(out_sat), 1);
    applyStimulus(4'b0100, pack4(0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    checkOutput("bnd_0_sat", 32'(out_sat), 0);
    applyStimulus(4'b0100, pack4(0, 0, 4095, 0), 1'b1, 1'b0, 1'b0);
    checkOutput("bnd_4095_data", 32'(out_data), 4095);
    checkOutput("bnd_4095_sat", 32'(out_sat), 0);
    applyStimulus(4'b0100, pack4(0, 0, 4096, 0), 1'b1, 1'b0, 1'b0);
    checkOutput("bnd_4096_data", 32'(out_data), 4095);
    checkOutput("bnd_4096_sat", 32'(out_sat), 1);
    applyStimulus(4'b0100, pack4(0, 0, -65536, 0), 1'b1, 1'b0, 1'b0);
    checkOutput("bnd_min_data", 32'(out_data), 0);
    checkOutput("bnd_sat_flags", 32'(sat_flags), 4'b0100);
    checkOutput("bnd_sat_cnt", 32'(sat_cnt), 3);

    // Backpressure with ch1 and ch3 waiting, then release (ptr points at ch3)
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1010, pack4(0, 11, 0, 33), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_in_ready", 32'(last_ready), 0);
    end
    applyStimulus(4'b1010, pack4(0, 11, 0, 33), 1'b1, 1'b0, 1'b0);
    checkOutput("bp_release_grant", 32'(last_ready), 4'b1000);
    applyStimulus(4'b1010, pack4(0, 11, 0, 33), 1'b1, 1'b0, 1'b0);

    // Fairness: ch0 always busy, ch3 joins and must be served within 4 cycles
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, pack4(7, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    got3 = 0;
    for (int i = 0; i < 4 && !got3; i++) begin
      applyStimulus(4'b1001, pack4(7, 0, 0, 9), 1'b1, 1'b0, 1'b0);
      got3 = last_ready[3];
    end
    checkOutput("fair_ch3_served", 32'(got3), 1);

    // Build flags=1001, cnt=7, then clear concurrent with a clipping ch1 grant
    applyStimulus(4'b0000, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_flags", 32'(sat_flags), 0);
    checkOutput("clr_cnt", 32'(sat_cnt), 0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, pack4(-3, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1000, pack4(0, 0, 0, 5000), 1'b1, 1'b0, 1'b0);
    checkOutput("pre_clr_flags", 32'(sat_flags), 4'b1001);
    checkOutput("pre_clr_cnt", 32'(sat_cnt), 7);
    applyStimulus(4'b0010, pack4(0, -1, 0, 0), 1'b1, 1'b1, 1'b0);
    checkOutput("clr_evt_flags", 32'(sat_flags), 4'b0010);
    checkOutput("clr_evt_cnt", 32'(sat_cnt), 1);

    // Counter ceiling
    for (int i = 0; i < 20; i++)
      applyStimulus(4'b0001 << $urandom_range(0, 3), pack4(5000, -2, 9000, -65536), 1'b1, 1'b0, 1'b0);
    checkOutput("ceil_cnt", 32'(sat_cnt), 15);
    checkOutput("ceil_valid", 32'(out_valid), 1);

    // Reset while holding a sample
    applyStimulus(4'b1111, pack4(1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
    checkOutput("rst_in_ready", 32'(last_ready), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_flags", 32'(sat_flags), 0);
    checkOutput("rst_cnt", 32'(sat_cnt), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)),
                    pack4(randSample(), randSample(), randSample(), randSample()),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
